imem_access_ctrl: RTL

IMEM_ACCESS_CTRL -- requirements
Module: imem_access_ctrl

---
 rtl/imem_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/imem_access_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// Holds the FSM state encoding, default geometry and the pc legality rule.
package imem_pkg;

  localparam int IMEM_ADDR_W     = 16;
  localparam int BYTES_PER_INSTR = 4;
  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_INSTR - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RDLAST = 3'd2,
    S_WR     = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  // A pc is unusable when it is not word aligned or lies beyond the memory.
  function automatic logic pc_is_bad(input logic [63:0] pc, input int unsigned addr_w);
    return (pc[1:0] != 2'b00) || ((pc >> addr_w) != 64'd0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the fetch port, bit 1 the loader.
// On a tie the requester that was not granted last wins; after reset the loader wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // last_q = 1 means the loader (bit 1) holds the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Byte-wide instruction memory access controller: assembles 32-bit little-endian
// fetches from four byte reads and performs single-byte loader writes.
module imem_access_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [63:0]       fetch_pc,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshake: each requester holds its req high until its completion pulse
  // (fetch_valid / ld_ack); a request is accepted only in an IDLE cycle where
  // the arbiter grants it, and the controller samples the request payload then.

  localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;
  logic              fetch_valid_q;
  logic              fetch_err_q;
  logic              ld_ack_q;
  logic [31:0]       instr_q;
  logic [23:0]       buf_q;

  logic [1:0] gnt;
  logic       arb_advance;
  logic [1:0] rd_lane;

  assign arb_advance = (state_q == S_IDLE);
  // Read data trails the address by RD_LAT cycles, so lane = count - latency.
  assign rd_lane = cnt_q - RD_LAT_C;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({ld_req, fetch_req}),
    .advance (arb_advance),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'd0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      ld_ack_q      <= 1'b0;
      instr_q       <= 32'd0;
      buf_q         <= 24'd0;
    end else begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      ld_ack_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'd0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 2'd0;
          if (gnt[0]) begin
            if (pc_is_bad(fetch_pc, ADDR_W)) begin
              state_q       <= S_ERR;
              fetch_valid_q <= 1'b1;
              fetch_err_q   <= 1'b1;
              instr_q       <= 32'd0;
            end else begin
              state_q    <= S_RD;
              mem_addr_q <= fetch_pc[ADDR_W-1:0];
            end
          end else if (gnt[1]) begin
            state_q     <= S_WR;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ld_addr;
            mem_wdata_q <= ld_data;
            ld_ack_q    <= 1'b1;
          end
        end
        S_RD: begin
          if (cnt_q >= RD_LAT_C) begin
            case (rd_lane)
              2'd0:    buf_q[7:0]   <= mem_rdata;
              2'd1:    buf_q[15:8]  <= mem_rdata;
              2'd2:    buf_q[23:16] <= mem_rdata;
              default: ;
            endcase
          end
          if (cnt_q == LAST_LANE) begin
            state_q       <= S_RDLAST;
            fetch_valid_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + 2'd1;
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        S_RDLAST: begin
          // The top byte arrives this cycle; keep the finished word for later.
          instr_q <= {mem_rdata, buf_q};
          cnt_q   <= 2'd0;
          state_q <= S_IDLE;
        end
        S_WR:    state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  // In RDLAST the last byte is forwarded straight from the memory so the
  // complete word is presented in the same cycle as fetch_valid.
  assign fetch_instr = (state_q == S_RDLAST) ? {mem_rdata, buf_q} : instr_q;
  assign ld_ack      = ld_ack_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule
